// File: rtl/calculator_final_keypad_ctrl_if.sv
// Avalon-MM slave bundle for the keypad controller: register bus plus level interrupt.
interface calculator_final_keypad_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/calculator_final_keypad_ctrl.sv
// 4x4 keypad scanner with per-scan debounce and a keycode FIFO behind an Avalon-MM slave.
// Optional macro KEYPAD_IRQ_EN enables the irq output and the writable CONTROL[0] bit.
module calculator_final_keypad_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    calculator_final_keypad_ctrl_if.slave       bus,
    output logic [3:0]                          col_out,
    input  logic [3:0]                          row_in
);

    localparam int unsigned SetW = $clog2(SETTLE_CYCLES);
    localparam int unsigned DbW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);
    localparam logic [DbW-1:0]  DbTarget   = DbW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] FifoFull   = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StConfirm, StHeld, StRelease} state_e;

    logic [3:0]      r_row_s1;
    logic [3:0]      r_row_s2;
    logic            r_active;
    logic            r_scan_en;
    logic [1:0]      r_col;
    logic [SetW-1:0] r_settle;
    logic [1:0]      r_hits;
    logic [3:0]      r_code;
    state_e          r_state;
    logic [3:0]      r_cand;
    logic [DbW-1:0]  r_dbcnt;
    logic [3:0]      r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            r_ovf;
    logic [31:0]     r_readdata;

    logic            w_rd;
    logic            w_wr_status;
    logic            w_wr_ctrl;
    logic            w_scan_en_d;
    logic            w_irq_en;
    logic [3:0]      w_rows;
    logic [2:0]      w_nrows;
    logic [1:0]      w_row_idx;
    logic            w_sample;
    logic            w_scan_done;
    logic [1:0]      w_hits_acc;
    logic [3:0]      w_code_acc;
    logic            w_none;
    logic            w_single;
    state_e          w_state_d;
    logic [3:0]      w_cand_d;
    logic [DbW-1:0]  w_dbcnt_d;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_do_push;
    logic            w_ovf_set;
    logic [3:0]      w_head;
    logic [4:0]      w_count5;
    logic [31:0]     w_rdata;
    logic            w_unused;

    // ---------------- bus decode ----------------
    assign w_rd        = bus.chipselect & bus.read;
    assign w_wr_status = bus.chipselect & bus.write & (bus.address == 2'd1);
    assign w_wr_ctrl   = bus.chipselect & bus.write & (bus.address == 2'd2);
    assign w_scan_en_d = w_wr_ctrl ? bus.writedata[1] : r_scan_en;

    // ---------------- row synchronizer and column scanner ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    assign col_out     = r_active ? ~(4'b0001 << r_col) : 4'hF;
    assign w_rows      = ~r_row_s2;
    assign w_sample    = r_active && (r_settle == SettleLast);
    assign w_scan_done = w_sample && (r_col == 2'd3);
    assign w_nrows     = {2'b00, w_rows[0]} + {2'b00, w_rows[1]}
                       + {2'b00, w_rows[2]} + {2'b00, w_rows[3]};

    always_comb begin
        w_row_idx = 2'd0;
        case (w_rows)
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    // Hit accumulation over one scan: 0 = none, 1 = single (r_code valid), 2 = multiple.
    always_comb begin
        w_hits_acc = r_hits;
        w_code_acc = r_code;
        if (w_sample) begin
            if (w_nrows >= 3'd2) begin
                w_hits_acc = 2'd2;
            end else if (w_nrows == 3'd1) begin
                if (r_hits == 2'd0) begin
                    w_hits_acc = 2'd1;
                    w_code_acc = {w_row_idx, r_col};
                end else begin
                    w_hits_acc = 2'd2;
                end
            end
        end
    end

    assign w_none   = (w_hits_acc == 2'd0);
    assign w_single = (w_hits_acc == 2'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_col    <= 2'd0;
            r_settle <= '0;
            r_hits   <= 2'd0;
            r_code   <= 4'd0;
        end else if (!w_scan_en_d) begin
            r_active <= 1'b0;
            r_col    <= 2'd0;
            r_settle <= '0;
            r_hits   <= 2'd0;
            r_code   <= 4'd0;
        end else begin
            r_active <= 1'b1;
            if (r_active) begin
                if (w_sample) begin
                    r_settle <= '0;
                    r_col    <= r_col + 2'd1;
                    r_hits   <= w_scan_done ? 2'd0 : w_hits_acc;
                    r_code   <= w_scan_done ? 4'd0 : w_code_acc;
                end else begin
                    r_settle <= r_settle + SetW'(1);
                end
            end
        end
    end

    // ---------------- debounce FSM, stepped once per completed scan ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cand  <= 4'd0;
            r_dbcnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_cand  <= w_cand_d;
            r_dbcnt <= w_dbcnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cand_d  = r_cand;
        w_dbcnt_d = r_dbcnt;
        w_push    = 1'b0;
        if (!w_scan_en_d) begin
            w_state_d = StIdle;
        end else if (w_scan_done) begin
            case (r_state)
                StIdle: begin
                    if (w_single) begin
                        w_cand_d  = w_code_acc;
                        w_dbcnt_d = DbW'(1);
                        w_state_d = StConfirm;
                    end
                end
                StConfirm: begin
                    if (w_single && (w_code_acc == r_cand)) begin
                        w_dbcnt_d = r_dbcnt + DbW'(1);
                        if (w_dbcnt_d == DbTarget) begin
                            w_push    = 1'b1;
                            w_state_d = StHeld;
                        end
                    end else begin
                        w_state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (w_none) begin
                        w_dbcnt_d = DbW'(1);
                        w_state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (w_none) begin
                        w_dbcnt_d = r_dbcnt + DbW'(1);
                        if (w_dbcnt_d == DbTarget) begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_state_d = StHeld;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // ---------------- keycode FIFO ----------------
    assign w_pop     = w_rd && (bus.address == 2'd0) && (r_count != '0);
    assign w_full    = (r_count == FifoFull);
    // A pop frees a slot on the same edge, so a push into a full queue still lands.
    assign w_do_push = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_head    = (r_count != '0) ? r_mem[r_rptr] : 4'd0;
    assign w_count5  = 5'(r_count);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= r_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && bus.writedata[8]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ---------------- control register and interrupt ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scan_en <= 1'b1;
        end else begin
            r_scan_en <= w_scan_en_d;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_irq_en <= bus.writedata[0];
        end
    end

    assign w_irq_en = r_irq_en;
    assign bus.irq  = r_irq_en & (r_count != '0);
    assign w_unused = ^{bus.writedata[31:9], bus.writedata[7:2]};
`else
    assign w_irq_en = 1'b0;
    assign bus.irq  = 1'b0;
    assign w_unused = ^{bus.writedata[31:9], bus.writedata[7:2], bus.writedata[0]};
`endif

    // ---------------- registered read data ----------------
    always_comb begin
        w_rdata = 32'd0;
        case (bus.address)
            2'd0:    w_rdata = {23'd0, (r_count != '0), 4'd0, w_head};
            2'd1:    w_rdata = {23'd0, r_ovf, 3'd0, w_count5};
            2'd2:    w_rdata = {30'd0, r_scan_en, w_irq_en};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_calculator_final_keypad_ctrl.sv
// Scoreboard bench for calculator_final_keypad_ctrl: keypad matrix model, spec-level debounce model.
module tb_calculator_final_keypad_ctrl;

    localparam int Settle = 4;
    localparam int Deb    = 3;
    localparam int Depth  = 4;
    localparam int PIdle = 0, PConf = 1, PHeld = 2, PRel = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic [15:0] keys = 16'd0;

    calculator_final_keypad_ctrl_if bus ();

    calculator_final_keypad_ctrl #(
        .SETTLE_CYCLES  (Settle),
        .DEBOUNCE_SCANS (Deb),
        .FIFO_DEPTH     (Depth)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .col_out (col_out),
        .row_in  (row_in)
    );

    always #5 clk = ~clk;

    // A row reads low when a pressed key sits on it and its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    int          total = 0;
    int          bad = 0;
    int          m_fifo[$];
    bit          m_ovf;
    int          m_phase;
    int          m_cand;
    int          m_cnt;
    bit          m_irq_en;
    bit          m_scan_en;
    logic [31:0] exp_q[$];
    logic        rd_issued = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf     = 1'b0;
        m_phase   = PIdle;
        m_cand    = 0;
        m_cnt     = 0;
        m_irq_en  = 1'b0;
        m_scan_en = 1'b1;
    endtask

    task automatic model_push(input int code);
        if (m_fifo.size() < Depth) m_fifo.push_back(code);
        else m_ovf = 1'b1;
    endtask

    // One completed scan: classify the key set, then apply the debounce rules.
    task automatic model_scan(input logic [15:0] k);
        int n;
        int code;
        n = $countones(k);
        code = 0;
        for (int i = 0; i < 16; i++) if (k[i]) code = i;
        case (m_phase)
            PIdle: if (n == 1) begin m_cand = code; m_cnt = 1; m_phase = PConf; end
            PConf: begin
                if (n == 1 && code == m_cand) begin
                    m_cnt++;
                    if (m_cnt == Deb) begin model_push(m_cand); m_phase = PHeld; end
                end else m_phase = PIdle;
            end
            PHeld: if (n == 0) begin m_cnt = 1; m_phase = PRel; end
            default: begin
                if (n == 0) begin
                    m_cnt++;
                    if (m_cnt == Deb) m_phase = PIdle;
                end else m_phase = PHeld;
            end
        endcase
    endtask

    // A wrap from column 3 to column 0 marks a scan that ran to completion.
    initial begin : scan_tracker
        logic [3:0]  prev_col;
        logic [15:0] keys_prev;
        prev_col  = 4'hF;
        keys_prev = 16'd0;
        forever begin
            @(negedge clk);
            if (prev_col == 4'h7 && col_out == 4'hE) model_scan(keys_prev);
            prev_col  = col_out;
            keys_prev = keys;
        end
    end

    always @(posedge clk) rd_issued <= bus.chipselect & bus.read;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rd_issued) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL readdata_unexpected: got 0x%08h expected no response",
                             bus.readdata);
                end else begin
                    total--;
                    check("readdata", bus.readdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic bus_read(input logic [1:0] a);
        logic [31:0] e;
        @(negedge clk);
        e = 32'd0;
        case (a)
            2'd0: if (m_fifo.size() > 0) e = 32'h100 | 32'(m_fifo.pop_front());
            2'd1: e = {23'd0, m_ovf, 3'd0, 5'(m_fifo.size())};
            2'd2: e = {30'd0, m_scan_en, m_irq_en};
            default: e = 32'd0;
        endcase
        exp_q.push_back(e);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        if (a == 2'd1 && d[8]) m_ovf = 1'b0;
        if (a == 2'd2) begin
`ifdef KEYPAD_IRQ_EN
            m_irq_en = d[0];
`endif
            m_scan_en = d[1];
            if (!d[1]) m_phase = PIdle;
        end
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic next_scan();
        logic [3:0] p;
        bit found;
        p = col_out;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (p == 4'h7 && col_out == 4'hE) found = 1'b1;
            p = col_out;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL scan_timeout: got no scan wrap expected one within 200 cycles");
        end
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        repeat (n) begin
            next_scan();
            keys = k;
        end
    endtask

    task automatic release_all();
        hold(16'd0, 4);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        keys    = 16'd0;
        repeat (n) @(negedge clk);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        check("reset_col_out", {28'd0, col_out}, 32'h0000000F);
        model_reset();
        reset_n = 1'b1;
        @(negedge clk);
        check("first_col_out", {28'd0, col_out}, 32'h0000000E);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 ns");
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] k;
        int          nk;
        int          j;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = 32'd0;
        model_reset();
        apply_reset(3);

        // Single key row2/col1 held for 5 scans.
        hold(16'h0001 << 9, 5);
        bus_read(2'd0);
        bus_read(2'd0);
        bus_read(2'd1);
        release_all();

        // Row0/col3 bouncing, then stable.
        for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 16'h0008 : 16'h0000, 1);
        hold(16'h0008, 3);
        release_all();
        bus_read(2'd1);
        bus_read(2'd0);

        // Five distinct keys overflow a four-deep queue.
        for (int c = 0; c < 5; c++) begin
            hold(16'h0001 << c, 4);
            release_all();
        end
        bus_read(2'd1);
        for (int i = 0; i < 4; i++) bus_read(2'd0);
        bus_write(2'd1, 32'h100);
        bus_read(2'd1);
        bus_read(2'd0);

        // Two keys together, then release one.
        hold((16'h0001 << 4) | (16'h0001 << 6), 6);
        bus_read(2'd1);
        hold(16'h0001 << 4, 4);
        release_all();
        bus_read(2'd0);

        // Interrupt enable and drop on pop.
        hold(16'h0001 << 5, 4);
        release_all();
        bus_write(2'd2, 32'h3);
        check("irq_queued", {31'd0, bus.irq}, {31'd0, m_irq_en && (m_fifo.size() != 0)});
        bus_read(2'd2);
        bus_read(2'd0);
        check("irq_after_pop", {31'd0, bus.irq}, {31'd0, m_irq_en && (m_fifo.size() != 0)});

        // Disable scanning mid-press.
        hold(16'h0001 << 10, 2);
        bus_write(2'd2, 32'h1);
        check("scan_off_col_out", {28'd0, col_out}, 32'h0000000F);
        keys = 16'd0;
        repeat (5) @(negedge clk);
        check("scan_off_col_idle", {28'd0, col_out}, 32'h0000000F);
        bus_write(2'd2, 32'h3);
        hold(16'h0001 << 10, 2);
        bus_read(2'd1);
        release_all();
        bus_read(2'd1);
        while (m_fifo.size() > 0) bus_read(2'd0);

        // Reset pulse mid-CONFIRM with two keys queued.
        for (int c = 12; c < 14; c++) begin
            hold(16'h0001 << c, 4);
            release_all();
        end
        bus_read(2'd1);
        hold(16'h0001 << 7, 2);
        apply_reset(1);
        hold(16'd0, 2);
        bus_read(2'd1);
        bus_read(2'd0);

        // Randomized key sets and bus traffic.
        for (int it = 0; it < 40; it++) begin
            k  = 16'd0;
            nk = $urandom_range(0, 2);
            if (nk >= 1) k[$urandom_range(0, 15)] = 1'b1;
            if (nk == 2) begin
                j = $urandom_range(0, 15);
                while (k[j]) j = $urandom_range(0, 15);
                k[j] = 1'b1;
            end
            hold(k, $urandom_range(1, 4));
            case ($urandom_range(0, 5))
                0: bus_read(2'd0);
                1: bus_read(2'd1);
                2: bus_write(2'd1, 32'h100);
                3: bus_read(2'd3);
                4: bus_write(2'd3, $urandom);
                default: ;
            endcase
        end
        release_all();
        for (int i = 0; i < Depth + 1; i++) bus_read(2'd0);
        bus_read(2'd1);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
